// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit and its pipeline registers.
//   NOP_INSTR        : encoding loaded into the IF/ID register for bubbles
//   DEFAULT_RESET_PC : default first fetch address after reset
//   ifu_state_t      : fetch control states (RUN / HALT)
package ifu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ifu_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction, its PC and a valid flag.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   en                  : load enable (hold when low)
//   ir_in, pc_in, valid_in : values captured on an enabled edge
//   ir, pc, valid       : registered outputs (reset to NOP / 0 / 0)
module ifid_reg
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] ir_in,
  input  logic [31:0] pc_in,
  input  logic        valid_in,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir    <= NOP_INSTR;
      pc    <= '0;
      valid <= 1'b0;
    end else if (en) begin
      ir    <= ir_in;
      pc    <= pc_in;
      valid <= valid_in;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: holds the fetch PC, addresses the instruction
// memory and captures the returned word into the IF/ID register.
// Ports:
//   Clk, Reset     : clock, asynchronous active-high reset
//   ImAddr         : word address to instruction memory (PcF[11:2])
//   ImData         : instruction returned for ImAddr in the same cycle
//   Stall          : hold PC and IF/ID register
//   Redirect       : decode-stage taken branch/jump, target in RedirectPC
//   PcF            : current fetch PC
//   IrD, PcD       : instruction and PC in the IF/ID register
//   Pc8D           : link address PcD+8
//   ValidD         : IrD is a real fetched instruction
//   AddrErr        : sticky fetch-address error (unit halted)
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [9:0]  ImAddr,
  input  logic [31:0] ImData,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] PcF,
  output logic [31:0] IrD,
  output logic [31:0] PcD,
  output logic [31:0] Pc8D,
  output logic        ValidD,
  output logic        AddrErr
);

  // Range bounds widened to 33 bits so the upper limit cannot wrap.
  localparam logic [32:0] RANGE_LO = {1'b0, RESET_PC};
  localparam logic [32:0] RANGE_HI = RANGE_LO + (33'(IM_WORDS) << 2);

  ifu_state_t  state, state_next;
  logic [31:0] pc, pc_next;
  logic        fetch_bad;
  logic [31:0] ld_ir;
  logic [31:0] ld_pc;
  logic        ld_valid;

  assign fetch_bad = (pc[1:0] != 2'b00)
                  || ({1'b0, pc} <  RANGE_LO)
                  || ({1'b0, pc} >= RANGE_HI);

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:  if (!Stall && fetch_bad) state_next = HALT;
      HALT: state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // Output logic: next PC and the values offered to the IF/ID register.
  // A Redirect in the same cycle only steers the next PC; the word being
  // fetched now (the delay slot) is still loaded into D.
  always_comb begin
    pc_next  = pc;
    ld_ir    = NOP_INSTR;
    ld_pc    = pc;
    ld_valid = 1'b0;
    unique case (state)
      RUN: begin
        if (!fetch_bad) begin
          ld_ir    = ImData;
          ld_valid = 1'b1;
          pc_next  = Redirect ? RedirectPC : pc + 32'd4;
        end
      end
      HALT: ;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       pc <= RESET_PC;
    else if (!Stall) pc <= pc_next;
  end

  ifid_reg u_ifid (
    .clk      (Clk),
    .rst      (Reset),
    .en       (~Stall),
    .ir_in    (ld_ir),
    .pc_in    (ld_pc),
    .valid_in (ld_valid),
    .ir       (IrD),
    .pc       (PcD),
    .valid    (ValidD)
  );

  assign PcF     = pc;
  assign ImAddr  = pc[11:2];
  assign Pc8D    = PcD + 32'd8;
  assign AddrErr = (state == HALT);

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  ImAddr;
  logic [31:0] ImData;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic [31:0] PcF, IrD, PcD, Pc8D;
  logic        ValidD, AddrErr;

  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] pcf;
    logic [31:0] ird;
    logic [31:0] pcd;
    logic        valid;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  // Scoreboard: {instruction, pc} expected in D for each accepted fetch.
  logic [63:0] sb[$];
  logic [31:0] model_pc;
  logic        model_halt;

  ifu #(.RESET_PC(32'h0000_3000), .IM_WORDS(1024)) dut (
    .Clk(Clk), .Reset(Reset), .ImAddr(ImAddr), .ImData(ImData),
    .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .PcF(PcF), .IrD(IrD), .PcD(PcD), .Pc8D(Pc8D),
    .ValidD(ValidD), .AddrErr(AddrErr)
  );

  always #5 Clk = ~Clk;
  assign ImData = mem[ImAddr];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic model_bad(input logic [31:0] p);
    return (p[1:0] != 2'b00) || (p < 32'h3000) || (p >= 32'h4000);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, ".PcF"},    PcF, 32'h3000);
    chk({tag, ".ImAddr"}, {22'd0, ImAddr}, 32'h0);
    chk({tag, ".IrD"},    IrD, 32'h0);
    chk({tag, ".PcD"},    PcD, 32'h0);
    chk({tag, ".Pc8D"},   Pc8D, 32'h8);
    chk({tag, ".ValidD"}, {31'd0, ValidD}, 32'd0);
    chk({tag, ".AddrErr"},{31'd0, AddrErr}, 32'd0);
  endtask

  // Pulse reset between clock edges (caller is at posedge+1).
  task automatic do_reset();
    Reset = 1'b1;
    #3;
    Reset = 1'b0;
    sb.delete();
    model_pc   = 32'h3000;
    model_halt = 1'b0;
  endtask

  // One clock with the given inputs; scoreboard push before the edge,
  // pop/compare after it.
  task automatic step(input logic st, input logic rd, input logic [31:0] rp);
    logic [63:0] e;
    Stall = st; Redirect = rd; RedirectPC = rp;
    if (!st && !model_halt) begin
      if (!model_bad(model_pc)) begin
        sb.push_back({mem[model_pc[11:2]], model_pc});
        model_pc = rd ? rp : model_pc + 32'd4;
      end else begin
        model_halt = 1'b1;
      end
    end
    @(posedge Clk); #1;
    if (!st) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb.IrD", IrD, e[63:32]);
        chk("sb.PcD", PcD, e[31:0]);
        chk("sb.ValidD", {31'd0, ValidD}, 32'd1);
      end else begin
        chk("sb.bubble", {31'd0, ValidD}, 32'd0);
      end
    end
    chk("model.PcF", PcF, model_pc);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[10'h040] = 32'h55; mem[10'h041] = 32'h66;

    // rst stall redir rpc        PcF          IrD           PcD          V  E
    vecs.push_back('{0,0,0,32'h0,    32'h3000_3004-32'h3000_0000, 32'h11, 32'h3000, 1,0});
    vecs.push_back('{0,0,0,32'h0,    32'h3008, 32'h22,        32'h3004, 1,0});
    vecs.push_back('{0,1,0,32'h0,    32'h3008, 32'h22,        32'h3004, 1,0});
    vecs.push_back('{0,1,0,32'h0,    32'h3008, 32'h22,        32'h3004, 1,0});
    vecs.push_back('{0,1,0,32'h0,    32'h3008, 32'h22,        32'h3004, 1,0});
    vecs.push_back('{0,0,0,32'h0,    32'h300C, 32'h33,        32'h3008, 1,0});
    vecs.push_back('{0,0,0,32'h0,    32'h3010, 32'h44,        32'h300C, 1,0});
    vecs.push_back('{1,0,0,32'h0,    32'h3004, 32'h11,        32'h3000, 1,0});
    vecs.push_back('{0,0,1,32'h3100, 32'h3100, 32'h22,        32'h3004, 1,0});
    vecs.push_back('{0,0,0,32'h0,    32'h3104, 32'h55,        32'h3100, 1,0});
    vecs.push_back('{0,1,1,32'h3200, 32'h3104, 32'h55,        32'h3100, 1,0});
    vecs.push_back('{0,0,1,32'h3200, 32'h3200, 32'h66,        32'h3104, 1,0});
    vecs.push_back('{0,0,1,32'h3FFC, 32'h3FFC, 32'hC000_0080, 32'h3200, 1,0});
    vecs.push_back('{0,0,0,32'h0,    32'h4000, 32'hC000_03FF, 32'h3FFC, 1,0});
    vecs.push_back('{0,0,0,32'h0,    32'h4000, 32'h0,         32'h4000, 0,1});
    vecs.push_back('{0,0,1,32'h3000, 32'h4000, 32'h0,         32'h4000, 0,1});

    model_pc = 32'h3000; model_halt = 1'b0;
    @(posedge Clk); #1;
    check_reset_vals("reset");
    Reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].stall, vecs[i].redir, vecs[i].rpc);
      chk($sformatf("v%0d.PcF", i), PcF, vecs[i].pcf);
      chk($sformatf("v%0d.ImAddr", i), {22'd0, ImAddr}, {22'd0, vecs[i].pcf[11:2]});
      chk($sformatf("v%0d.IrD", i), IrD, vecs[i].ird);
      chk($sformatf("v%0d.PcD", i), PcD, vecs[i].pcd);
      chk($sformatf("v%0d.Pc8D", i), Pc8D, vecs[i].pcd + 32'd8);
      chk($sformatf("v%0d.ValidD", i), {31'd0, ValidD}, {31'd0, vecs[i].valid});
      chk($sformatf("v%0d.AddrErr", i), {31'd0, AddrErr}, {31'd0, vecs[i].err});
    end

    // Bad redirect targets: misaligned, below range, at upper limit.
    begin
      logic [31:0] tgt [3];
      tgt[0] = 32'h3002; tgt[1] = 32'h2FFC; tgt[2] = 32'h4000;
      for (int t = 0; t < 3; t++) begin
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, tgt[t]);
        chk($sformatf("err%0d.accept", t), PcF, tgt[t]);
        chk($sformatf("err%0d.pre_err", t), {31'd0, AddrErr}, 32'd0);
        for (int k = 0; k < 4; k++) begin
          step(k == 2, k == 1, 32'h3000);
          chk($sformatf("err%0d.%0d.AddrErr", t, k), {31'd0, AddrErr}, 32'd1);
          chk($sformatf("err%0d.%0d.ValidD", t, k), {31'd0, ValidD}, 32'd0);
          chk($sformatf("err%0d.%0d.IrD", t, k), IrD, 32'h0);
          chk($sformatf("err%0d.%0d.PcF", t, k), PcF, tgt[t]);
        end
      end
    end

    // Asynchronous reset between edges, then restart at 0x3000.
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("async.pre", PcF, 32'h3008);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_vals("async");
    #1;
    Reset = 1'b0;
    sb.delete();
    model_pc = 32'h3000; model_halt = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    chk("restart.IrD", IrD, 32'h11);
    chk("restart.PcD", PcD, 32'h3000);
    step(1'b0, 1'b0, 32'h0);
    chk("restart.PcF", PcF, 32'h3008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
